burst_gate: RTL and testbench

BURST_GATE -- requirements
Module: burst_gate

---
 rtl/burst_gate.sv | 113 +++++++++++
 tb/tb_burst_gate.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/burst_gate.sv
// burst_gate: gates a free-running PWM into whole-cycle ping bursts, then blanks the receiver.
// Optional abort input is built in when BURST_GATE_ABORT_EN is defined.
module burst_gate #(
  parameter int unsigned MAX_PULSES     = 32,
  parameter int unsigned HOLDOFF_CLOCKS = 50000,
  localparam int unsigned CW = $clog2(MAX_PULSES + 1),
  localparam int unsigned HW = (HOLDOFF_CLOCKS > 1) ? $clog2(HOLDOFF_CLOCKS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          pwm_in,
  input  logic          trigger_in,
  input  logic [CW-1:0] num_cycles_in,
`ifdef BURST_GATE_ABORT_EN
  input  logic          abort_in,
`endif
  output logic          tx_out,
  output logic          busy_out,
  output logic          blank_out,
  output logic          done_out,
  output logic [CW-1:0] pulse_count_out
);

  localparam int unsigned HoldLast = (HOLDOFF_CLOCKS > 0) ? HOLDOFF_CLOCKS - 1 : 0;

  typedef enum logic [1:0] {StIdle, StAlign, StBurst, StHoldoff} state_e;

  state_e        state_q;
  logic          pwm_q;
  logic [CW-1:0] target_q;
  logic [CW-1:0] count_q;
  logic [HW-1:0] hold_q;

  logic          rise;
  logic          fall;
  logic          abort;
  logic          hold_end;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] num_clamped;

  assign rise        = pwm_in & ~pwm_q;
  assign fall        = ~pwm_in & pwm_q;
  assign hold_end    = (hold_q == HW'(HoldLast));
  assign count_inc   = count_q + 1'b1;
  assign num_clamped = (num_cycles_in > CW'(MAX_PULSES)) ? CW'(MAX_PULSES) : num_cycles_in;

`ifdef BURST_GATE_ABORT_EN
  assign abort = abort_in;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      pwm_q    <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      pwm_q <= pwm_in;
      case (state_q)
        StIdle: begin
          if (trigger_in && (num_cycles_in != '0)) begin
            target_q <= num_clamped;
            count_q  <= '0;
            state_q  <= StAlign;
          end
        end
        StAlign: begin
          if (abort) begin
            hold_q  <= '0;
            state_q <= StHoldoff;
          end else if (rise) begin
            state_q <= StBurst;
          end
        end
        StBurst: begin
          // Abort wins over a coincident fall so the count stays frozen.
          if (abort) begin
            hold_q  <= '0;
            state_q <= StHoldoff;
          end else if (fall) begin
            count_q <= count_inc;
            if (count_inc == target_q) begin
              hold_q  <= '0;
              state_q <= StHoldoff;
            end
          end
        end
        StHoldoff: begin
          if (hold_end) begin
            hold_q  <= '0;
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Driving only from the aligned rise onward means no partial first pulse.
  assign tx_out = ~rst_in & ~abort & pwm_in &
                  ((state_q == StBurst) | ((state_q == StAlign) & rise));

  assign busy_out        = ~rst_in & (state_q != StIdle);
  assign blank_out       = ~rst_in & (state_q != StIdle);
  assign done_out        = ~rst_in & (state_q == StHoldoff) & hold_end;
  assign pulse_count_out = count_q;

endmodule

// File: tb/tb_burst_gate.sv
// Self-checking bench for burst_gate: table of burst scenarios plus hand-written corner sequences.
module tb_burst_gate;

  localparam int unsigned MAXP = 8;
  localparam int unsigned HOLD = 20;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm = 1'b0;
  logic          trigger = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic          tx;
  logic          busy;
  logic          blank;
  logic          done;
  logic [CW-1:0] pulse_count;

  int phase = 0;
  int n_cmp = 0;
  int n_bad = 0;

  burst_gate #(
    .MAX_PULSES    (MAXP),
    .HOLDOFF_CLOCKS(HOLD)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .pwm_in         (pwm),
    .trigger_in     (trigger),
    .num_cycles_in  (num_cycles),
`ifdef BURST_GATE_ABORT_EN
    .abort_in       (abort),
`endif
    .tx_out         (tx),
    .busy_out       (busy),
    .blank_out      (blank),
    .done_out       (done),
    .pulse_count_out(pulse_count)
  );

  initial forever #5 clk = ~clk;

  // 10-clock PWM, high for phases 0..4, updated 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 10;
      pwm   = (phase < 5);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one burst for a fixed window, measuring what tx/done/busy did.
  task automatic burst(input int num, input int ph, input int mid_at, input bit done_trig,
                       input int abort_at, input int rst_at,
                       output int pulses, output int dones, output int f2d, output int bad,
                       output int final_count);
    int  run_len, since, wait_cnt;
    bit  prev_tx, prev_pwm, mid_sent, ev_sent, ab_cyc, rst_cyc, rst_seen, post_rst, after_done;
    pulses = 0; dones = 0; f2d = -1; bad = 0;
    run_len = 0; since = -1; wait_cnt = 0;
    mid_sent = 0; ev_sent = 0; rst_seen = 0; post_rst = 0; after_done = 0;
    do begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end while (phase != ph && wait_cnt < 20);
    trigger    = 1'b1;
    num_cycles = CW'(num);
    @(negedge clk);
    prev_tx  = tx;
    prev_pwm = pwm;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #2;
      trigger = 1'b0; abort = 1'b0; rst = 1'b0;
      ab_cyc = 0; rst_cyc = 0;
      if (mid_at > 0 && pulses == mid_at && !mid_sent) begin
        trigger = 1'b1; num_cycles = CW'(2); mid_sent = 1;
      end
      if (done_trig && since == int'(HOLD) - 1) begin
        trigger = 1'b1; num_cycles = CW'(3);
      end
      if (abort_at > 0 && pulses == abort_at && phase == 2 && !ev_sent) begin
        abort = 1'b1; ev_sent = 1; ab_cyc = 1;
      end
      if (rst_at > 0 && pulses == rst_at && phase == 2 && !ev_sent) begin
        rst = 1'b1; ev_sent = 1; rst_cyc = 1;
      end
      @(negedge clk);
      if (post_rst) begin
        check("post_reset_outputs", {tx, busy, blank, done, pulse_count}, '0);
        post_rst = 0;
      end
      if (ab_cyc) begin
        check("abort_cuts_tx", {31'd0, tx}, 32'd0);
        run_len = 0; since = 0;
      end else if (rst_cyc) begin
        run_len = 0; since = -1; rst_seen = 1; post_rst = 1;
      end else begin
        if (tx && !pwm) bad++;
        if (tx && !prev_tx && prev_pwm) bad++;
        if (tx) run_len++;
        if (!tx && prev_tx) begin
          pulses++;
          if (run_len != 5) bad++;
          run_len = 0; since = 0;
        end else if (since >= 0) begin
          since++;
        end
      end
      if (busy !== blank) bad++;
      if (num > 0 && dones == 0 && !rst_seen && !busy) bad++;
      if ((num == 0 || after_done || (rst_seen && !rst_cyc)) && busy) bad++;
      if (done) begin
        dones++; f2d = since; after_done = 1;
      end
      prev_tx  = tx;
      prev_pwm = pwm;
    end
    final_count = int'(pulse_count);
  endtask

  typedef struct {
    int num;
    int ph;
    int exp_pulses;
    int exp_count;
    int exp_dones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p, d, f, b, fc;
    vecs[0] = '{num: 3,  ph: 7, exp_pulses: 3, exp_count: 3, exp_dones: 1};
    vecs[1] = '{num: 0,  ph: 7, exp_pulses: 0, exp_count: 3, exp_dones: 0};
    vecs[2] = '{num: 12, ph: 0, exp_pulses: 8, exp_count: 8, exp_dones: 1};
    vecs[3] = '{num: 1,  ph: 2, exp_pulses: 1, exp_count: 1, exp_dones: 1};
    vecs[4] = '{num: 8,  ph: 9, exp_pulses: 8, exp_count: 8, exp_dones: 1};
    vecs[5] = '{num: 5,  ph: 4, exp_pulses: 5, exp_count: 5, exp_dones: 1};

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_blank", {31'd0, blank}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_count", {28'd0, pulse_count}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      burst(vecs[i].num, vecs[i].ph, 0, 0, 0, 0, p, d, f, b, fc);
      check($sformatf("vec%0d_pulses", i), p, vecs[i].exp_pulses);
      check($sformatf("vec%0d_count", i), fc, vecs[i].exp_count);
      check($sformatf("vec%0d_dones", i), d, vecs[i].exp_dones);
      check($sformatf("vec%0d_protocol", i), b, 0);
      if (vecs[i].exp_dones > 0) check($sformatf("vec%0d_holdoff", i), f, HOLD);
    end

    // Retrigger during BURST and during the done clock: both must be dropped.
    burst(4, 7, 1, 1, 0, 0, p, d, f, b, fc);
    check("retrig_pulses", p, 4);
    check("retrig_dones", d, 1);
    check("retrig_holdoff", f, HOLD);
    check("retrig_count", fc, 4);
    check("retrig_protocol", b, 0);

    // Reset in the third pulse of a 5-pulse burst, then a fresh burst.
    burst(5, 7, 0, 0, 0, 2, p, d, f, b, fc);
    check("rst_pulses", p, 2);
    check("rst_dones", d, 0);
    check("rst_count", fc, 0);
    check("rst_protocol", b, 0);
    burst(2, 3, 0, 0, 0, 0, p, d, f, b, fc);
    check("after_rst_pulses", p, 2);
    check("after_rst_dones", d, 1);
    check("after_rst_holdoff", f, HOLD);
    check("after_rst_count", fc, 2);
    check("after_rst_protocol", b, 0);

`ifdef BURST_GATE_ABORT_EN
    burst(6, 7, 0, 0, 2, 0, p, d, f, b, fc);
    check("abort_pulses", p, 2);
    check("abort_count", fc, 2);
    check("abort_dones", d, 1);
    check("abort_holdoff", f, HOLD);
    check("abort_protocol", b, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
